// File: rtl/e_scale_pkg.sv
// E-scale parameter buffer shared definitions.
// Widths and depths of the ping-pong tile buffer, the bank state encoding
// and the bit positions of the tail/rank fields inside a load beat.
package e_scale_pkg;

    localparam int SETS_NUM           = 64;
    localparam int SETS_NUM_IN_2POW   = 6;
    localparam int E_SCALE_TAIL_SET_W = 32;
    localparam int E_SCALE_RANK_SET_W = 16;
    localparam int LOAD_W             = E_SCALE_RANK_SET_W + E_SCALE_TAIL_SET_W;

    // Entry counts need one extra bit so a full tile (64) is representable.
    localparam int CNT_W = SETS_NUM_IN_2POW + 1;

    // load_data = {rank_set, tail_set}
    localparam int TAIL_LSB = 0;
    localparam int TAIL_MSB = TAIL_LSB + E_SCALE_TAIL_SET_W - 1;
    localparam int RANK_LSB = TAIL_MSB + 1;
    localparam int RANK_MSB = RANK_LSB + E_SCALE_RANK_SET_W - 1;

    localparam logic [SETS_NUM_IN_2POW-1:0] IDX_LAST = SETS_NUM_IN_2POW'(SETS_NUM - 1);

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

endpackage

// File: rtl/e_scale_bank.sv
// One tile bank: SETS_NUM x LOAD_W array, single write port, registered read.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata  write one entry
//   re/raddr        read request; rdata updates the following cycle
//   rdata           registered read data, holds while re is low
module e_scale_bank
    import e_scale_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [SETS_NUM_IN_2POW-1:0] waddr,
    input  logic [LOAD_W-1:0]           wdata,
    input  logic                        re,
    input  logic [SETS_NUM_IN_2POW-1:0] raddr,
    output logic [LOAD_W-1:0]           rdata
);

    logic [LOAD_W-1:0] mem [SETS_NUM];
    logic [LOAD_W-1:0] rdata_q;
    logic [LOAD_W-1:0] rdata_d;

    // Array contents are not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/e_scale_param_buf.sv
// Ping-pong E-scale parameter buffer feeding the E-scale quantifier.
// A tile of up to SETS_NUM {rank_set, tail_set} entries is loaded into one
// bank while the other bank is replayed to the quantifier.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   load_valid/load_ready      load handshake: a beat transfers on a cycle
//                              where both are high; load_ready does not
//                              depend on load_valid
//   load_data, load_last       beat payload {rank_set, tail_set}, tile end
//   params_ready               read bank holds a complete tile
//   rd_en                      present the next entry (one-cycle latency)
//   tile_release               free the read bank, advance to the next tile
//   E_scale_tail_set/rank_set  presented entry, held between reads
//   set_valid, set_wrap        pulse when an entry / the last entry is shown
//   rd_err                     sticky: read or release with no tile ready
//   dbg_bank_full              per-bank state (1 = FULL), for observation
module e_scale_param_buf
    import e_scale_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [LOAD_W-1:0]             load_data,
    input  logic                          load_last,
    output logic                          params_ready,
    input  logic                          rd_en,
    input  logic                          tile_release,
    output logic [E_SCALE_TAIL_SET_W-1:0] E_scale_tail_set,
    output logic [E_SCALE_RANK_SET_W-1:0] E_scale_rank_set,
    output logic                          set_valid,
    output logic                          set_wrap,
    output logic                          rd_err,
    output logic [1:0]                    dbg_bank_full
);

    bank_state_e                 bank_state_q [2];
    bank_state_e                 bank_state_d [2];
    logic [CNT_W-1:0]            count_q [2];
    logic [CNT_W-1:0]            count_d [2];
    logic                        wr_sel_q, wr_sel_d;
    logic                        rd_sel_q, rd_sel_d;
    logic [SETS_NUM_IN_2POW-1:0] wr_idx_q, wr_idx_d;
    logic [SETS_NUM_IN_2POW-1:0] rd_idx_q, rd_idx_d;
    logic                        out_sel_q, out_sel_d;
    logic                        set_valid_q, set_valid_d;
    logic                        set_wrap_q, set_wrap_d;
    logic                        rd_err_q, rd_err_d;

    logic                        load_accept;
    logic                        load_close;
    logic                        rd_accept;
    logic                        rel_accept;
    logic                        rd_last;
    logic [1:0]                  bank_we;
    logic [1:0]                  bank_re;
    logic [LOAD_W-1:0]           bank_rdata [2];
    logic [LOAD_W-1:0]           out_data;

    assign load_ready   = (bank_state_q[wr_sel_q] == BANK_EMPTY);
    assign params_ready = (bank_state_q[rd_sel_q] == BANK_FULL);

    always_comb begin
        bank_state_d = bank_state_q;
        count_d      = count_q;
        wr_sel_d     = wr_sel_q;
        rd_sel_d     = rd_sel_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        out_sel_d    = out_sel_q;

        load_accept = load_valid && load_ready;
        // The last slot of a bank closes the tile even without load_last.
        load_close  = load_accept && (load_last || (wr_idx_q == IDX_LAST));
        rd_accept   = rd_en && params_ready;
        rel_accept  = tile_release && params_ready;
        rd_last     = ({1'b0, rd_idx_q} == (count_q[rd_sel_q] - CNT_W'(1)));

        // Load side
        if (load_accept) begin
            wr_idx_d = wr_idx_q + SETS_NUM_IN_2POW'(1);
        end
        if (load_close) begin
            count_d[wr_sel_q]      = {1'b0, wr_idx_q} + CNT_W'(1);
            bank_state_d[wr_sel_q] = BANK_FULL;
            wr_sel_d               = ~wr_sel_q;
            wr_idx_d               = '0;
        end

        // Read side: the read is issued against the current bank before a
        // same-cycle release moves rd_sel on.
        set_valid_d = rd_accept;
        set_wrap_d  = rd_accept && rd_last;
        if (rd_accept) begin
            out_sel_d = rd_sel_q;
            rd_idx_d  = rd_last ? '0 : rd_idx_q + SETS_NUM_IN_2POW'(1);
        end

        // Release can never target the bank being closed: a closing bank is
        // EMPTY, a released bank is FULL.
        if (rel_accept) begin
            bank_state_d[rd_sel_q] = BANK_EMPTY;
            count_d[rd_sel_q]      = '0;
            rd_sel_d               = ~rd_sel_q;
            rd_idx_d               = '0;
        end

        rd_err_d = rd_err_q || ((rd_en || tile_release) && !params_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            count_q[0]      <= '0;
            count_q[1]      <= '0;
            wr_sel_q        <= 1'b0;
            rd_sel_q        <= 1'b0;
            wr_idx_q        <= '0;
            rd_idx_q        <= '0;
            out_sel_q       <= 1'b0;
            set_valid_q     <= 1'b0;
            set_wrap_q      <= 1'b0;
            rd_err_q        <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            count_q      <= count_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            out_sel_q    <= out_sel_d;
            set_valid_q  <= set_valid_d;
            set_wrap_q   <= set_wrap_d;
            rd_err_q     <= rd_err_d;
        end
    end

    assign bank_we[0] = load_accept && !wr_sel_q;
    assign bank_we[1] = load_accept &&  wr_sel_q;
    assign bank_re[0] = rd_accept   && !rd_sel_q;
    assign bank_re[1] = rd_accept   &&  rd_sel_q;

    e_scale_bank u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we[0]),
        .waddr (wr_idx_q),
        .wdata (load_data),
        .re    (bank_re[0]),
        .raddr (rd_idx_q),
        .rdata (bank_rdata[0])
    );

    e_scale_bank u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we[1]),
        .waddr (wr_idx_q),
        .wdata (load_data),
        .re    (bank_re[1]),
        .raddr (rd_idx_q),
        .rdata (bank_rdata[1])
    );

    // Each bank's read register holds its last entry, so selecting by the
    // bank most recently read keeps the outputs stable between reads.
    assign out_data         = bank_rdata[out_sel_q];
    assign E_scale_tail_set = out_data[TAIL_MSB:TAIL_LSB];
    assign E_scale_rank_set = out_data[RANK_MSB:RANK_LSB];
    assign set_valid        = set_valid_q;
    assign set_wrap         = set_wrap_q;
    assign rd_err           = rd_err_q;
    assign dbg_bank_full    = {bank_state_q[1] == BANK_FULL, bank_state_q[0] == BANK_FULL};

endmodule
